multicycle_datapath: RTL and testbench

//  Parametrised next-generation CPU datapath with integrated multicycle control FSM,
//  PC register and register file. Fetches and executes one instruction at a time over a

---
 rtl/multicycle_datapath.sv | 152 +++++++++++++++
 tb/tb_multicycle_datapath.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_datapath.sv
// Multicycle CPU core: control FSM, PC, register file and ALU. The core executes one
// instruction at a time over a single shared memory port that uses a req/done handshake.
module multicycle_datapath #(
  parameter int                DATA_W   = 13,
  parameter int                REG_AW   = 3,
  parameter int                IMM_W    = 4,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic [DATA_W-1:0] pc,
  output logic              retired,
  output logic              busy
);
  localparam int NREGS = 1 << REG_AW;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_LD   = 3'd5;
  localparam logic [2:0] OP_ST   = 3'd6;
  localparam logic [2:0] OP_BEQ  = 3'd7;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   pc_q, ir_q, a_q, b_q, alu_q, mdr_q;
  logic [DATA_W-1:0]   regs_q [NREGS];
  logic                mem_req_q, mem_we_q, retired_q;
  logic [DATA_W-1:0]   mem_addr_q, mem_wdata_q;

  logic [2:0]          op;
  logic [REG_AW-1:0]   rd, rs, rt;
  logic [DATA_W-1:0]   imm_sx, alu_d, br_pc_d;

  assign op     = ir_q[DATA_W-1 -: 3];
  assign rd     = ir_q[DATA_W-4 -: REG_AW];
  assign rs     = ir_q[DATA_W-4-REG_AW -: REG_AW];
  assign rt     = ir_q[DATA_W-4-2*REG_AW -: REG_AW];
  assign imm_sx = {{(DATA_W-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};

  // ADDI, LD and ST all share the base+offset path
  always_comb begin
    alu_d = a_q + imm_sx;
    case (op)
      OP_ADD:  alu_d = a_q + b_q;
      OP_SUB:  alu_d = a_q - b_q;
      OP_AND:  alu_d = a_q & b_q;
      OP_OR:   alu_d = a_q | b_q;
      default: alu_d = a_q + imm_sx;
    endcase
  end

  // pc already points past the branch when EXEC runs
  assign br_pc_d = (a_q == b_q) ? pc_q + imm_sx : pc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      alu_q       <= '0;
      mdr_q       <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      retired_q   <= 1'b0;
    end else begin
      retired_q <= 1'b0;
      case (state_q)
        S_IDLE: if (run) begin
          state_q    <= S_FETCH;
          mem_req_q  <= 1'b1;
          mem_we_q   <= 1'b0;
          mem_addr_q <= pc_q;
        end
        S_FETCH: if (mem_done) begin
          ir_q      <= mem_rdata;
          pc_q      <= pc_q + DATA_W'(1);
          mem_req_q <= 1'b0;
          state_q   <= S_DECODE;
        end
        S_DECODE: begin
          a_q     <= regs_q[rs];
          b_q     <= (op == OP_ST || op == OP_BEQ) ? regs_q[rd] : regs_q[rt];
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          alu_q <= alu_d;
          if (op == OP_BEQ) begin
            pc_q       <= br_pc_d;
            retired_q  <= 1'b1;
            state_q    <= S_FETCH;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= br_pc_d;
          end else if (op == OP_LD || op == OP_ST) begin
            state_q     <= S_MEM;
            mem_req_q   <= 1'b1;
            mem_we_q    <= (op == OP_ST);
            mem_addr_q  <= alu_d;
            mem_wdata_q <= b_q;
          end else begin
            state_q <= S_WB;
          end
        end
        S_MEM: if (mem_done) begin
          mem_we_q <= 1'b0;
          if (op == OP_LD) begin
            mdr_q     <= mem_rdata;
            mem_req_q <= 1'b0;
            state_q   <= S_WB;
          end else begin
            // store retires here; req stays high into the next fetch
            retired_q  <= 1'b1;
            state_q    <= S_FETCH;
            mem_addr_q <= pc_q;
          end
        end
        S_WB: begin
          if (rd != '0) regs_q[rd] <= (op == OP_LD) ? mdr_q : alu_q;
          retired_q  <= 1'b1;
          state_q    <= S_FETCH;
          mem_req_q  <= 1'b1;
          mem_we_q   <= 1'b0;
          mem_addr_q <= pc_q;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pc        = pc_q;
  assign retired   = retired_q;
  assign busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_multicycle_datapath.sv
// Scoreboard bench: an ISA-level model predicts every memory transaction and retirement;
// a monitor that also plays the memory checks what the core actually does.
module tb_multicycle_datapath;
  localparam int W = 13;

  logic         clk = 1'b0, reset = 1'b1, run = 1'b0, mem_done = 1'b0;
  logic [W-1:0] mem_rdata = '0;
  logic         mem_req, mem_we, retired, busy;
  logic [W-1:0] mem_addr, mem_wdata, pc;

  multicycle_datapath #(.DATA_W(W), .REG_AW(3), .IMM_W(4), .RESET_PC('0)) dut (
    .clk(clk), .reset(reset), .run(run), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_done(mem_done), .pc(pc), .retired(retired), .busy(busy));

  always #5 clk = ~clk;

  typedef struct {
    int           kind;   // 0 fetch, 1 data access, 2 retire (addr holds the new pc)
    logic [W-1:0] addr;
    logic         we;
    logic [W-1:0] wdata;
    int           lat;
  } ev_t;

  logic [W-1:0] tb_mem  [8192];
  logic [W-1:0] ref_mem [8192];
  logic [W-1:0] ref_reg [8];
  ev_t          exp_q [$];

  int tests = 0, fails = 0;
  bit mon_en = 1'b0;
  int ret_cnt = 0, ret_target = 0, wait_mode = 0, cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] sx4(input logic [3:0] i);
    return {{(W-4){i[3]}}, i};
  endfunction

  function automatic logic [W-1:0] enc(input int op, input int rd, input int rs, input logic [3:0] lo);
    logic [2:0] o, d, s;
    o = 3'(op); d = 3'(rd); s = 3'(rs);
    return {o, d, s, lo};
  endfunction

  // Instruction-level reference: runs n instructions and queues the expected bus activity
  task automatic model_run(input int n);
    logic [W-1:0] p, ins, a, b, d, res, ea;
    int op, lat;
    bit wr;
    p = '0;
    for (int k = 0; k < n; k++) begin
      ins = ref_mem[p];
      exp_q.push_back('{0, p, 1'b0, '0, 0});
      p   = p + 1;
      op  = int'(ins[12:10]);
      a   = ref_reg[ins[6:4]];
      b   = ref_reg[ins[3:1]];
      d   = ref_reg[ins[9:7]];
      wr  = 1'b1;
      lat = 5;
      res = '0;
      case (op)
        0: res = a + b;
        1: res = a - b;
        2: res = a & b;
        3: res = a | b;
        4: res = a + sx4(ins[3:0]);
        5: begin
          ea = a + sx4(ins[3:0]);
          exp_q.push_back('{1, ea, 1'b0, '0, 0});
          res = ref_mem[ea];
          lat = 6;
        end
        6: begin
          ea = a + sx4(ins[3:0]);
          exp_q.push_back('{1, ea, 1'b1, d, 0});
          ref_mem[ea] = d;
          wr = 1'b0;
        end
        default: begin
          if (d == a) p = p + sx4(ins[3:0]);
          wr  = 1'b0;
          lat = 4;
        end
      endcase
      if (wr && ins[9:7] != 3'd0) ref_reg[ins[9:7]] = res;
      exp_q.push_back('{2, p, 1'b0, '0, lat});
    end
  endtask

  // Monitor + memory responder
  initial begin
    bit           in_txn;
    int           wleft, fs, stalls;
    logic [W-1:0] t_addr, t_wdata;
    logic         t_we;
    ev_t          ev;
    in_txn = 0; wleft = 0; fs = 0; stalls = 0;
    forever begin
      @(negedge clk);
      cyc++;
      mem_done = 1'b0;
      if (reset) begin
        in_txn = 0;
        stalls = 0;
      end else begin
        if (retired && mon_en) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL retire_unexpected: got retire expected none (cycle %0d)", cyc);
          end else begin
            ev = exp_q.pop_front();
            chk("retire_kind", ev.kind, 2);
            chk("retire_pc", pc, ev.addr);
            chk("latency", cyc - fs + 1, ev.lat + stalls);
            ret_cnt++;
            if (ret_cnt == ret_target) mon_en = 1'b0;
          end
          stalls = 0;
        end
        if (mem_req && !in_txn) begin
          in_txn  = 1;
          t_addr  = mem_addr;
          t_we    = mem_we;
          t_wdata = mem_wdata;
          case (wait_mode)
            0:       wleft = 0;
            1:       wleft = $urandom_range(0, 2);
            2:       wleft = (mem_addr == 13'd3 && !mem_we) ? 4 : 0;
            default: wleft = 10;
          endcase
          if (mon_en && exp_q.size() > 0 && exp_q[0].kind == 0) fs = cyc;
        end else if (in_txn && mem_req && mon_en) begin
          chk("stable_addr", mem_addr, t_addr);
          chk("stable_we", mem_we, t_we);
          if (t_we) chk("stable_wdata", mem_wdata, t_wdata);
        end
        if (in_txn) begin
          if (!mem_req) begin
            in_txn = 0;
            if (mon_en) begin
              tests++; fails++;
              $display("FAIL req_dropped: got mem_req 0 expected 1 (cycle %0d)", cyc);
            end
          end else if (wleft == 0) begin
            mem_done  = 1'b1;
            mem_rdata = tb_mem[mem_addr];
            if (mem_we) tb_mem[mem_addr] = mem_wdata;
            in_txn = 0;
            if (mon_en) begin
              if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL txn_unexpected: got addr %0h expected none", mem_addr);
              end else begin
                ev = exp_q.pop_front();
                chk("txn_kind_is_mem", ev.kind == 2, 0);
                chk("txn_addr", mem_addr, ev.addr);
                chk("txn_we", mem_we, ev.we);
                if (ev.we) chk("txn_wdata", mem_wdata, ev.wdata);
              end
            end
          end else begin
            wleft--;
            stalls++;
          end
        end else if (wait_mode == 1 && !mem_req && $urandom_range(0, 3) == 0) begin
          mem_done = 1'b1;  // stray strobe, must be ignored
        end
      end
    end
  end

  task automatic sync_ref_mem();
    for (int i = 0; i < 8192; i++) ref_mem[i] = tb_mem[i];
  endtask

  task automatic start_run(input int n, input int mode);
    reset = 1'b1; run = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    for (int i = 0; i < 8; i++) ref_reg[i] = '0;
    model_run(n);
    wait_mode = mode; ret_target = n; ret_cnt = 0; mon_en = 1'b1;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
  endtask

  task automatic wait_done(input int n);
    for (int c = 0; c < 20 * n + 100 && ret_cnt < n; c++) @(negedge clk);
    chk("retire_count", ret_cnt, n);
    chk("queue_empty", exp_q.size(), 0);
    mon_en = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int c;
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_pc", pc, 0);
    chk("rst_retired", retired, 0);
    chk("rst_busy", busy, 0);

    // directed program, slow load from address 3
    for (int i = 0; i < 8192; i++) tb_mem[i] = W'($urandom);
    tb_mem[0]  = enc(5, 1, 0, 4'h8);   // LD r1,[r0-8]
    tb_mem[1]  = enc(5, 2, 0, 4'h9);   // LD r2,[r0-7]
    tb_mem[2]  = enc(0, 3, 1, 4'h4);   // ADD r3,r1,r2
    tb_mem[3]  = 13'h0ABC;             // AND r5,r3,r6 (also load data)
    tb_mem[4]  = enc(6, 3, 0, 4'hA);   // ST r3,[r0-6]
    tb_mem[5]  = enc(4, 4, 0, 4'hE);   // ADDI r4,r0,-2
    tb_mem[6]  = enc(4, 5, 4, 4'h1);   // ADDI r5,r4,1
    tb_mem[7]  = enc(6, 4, 0, 4'hB);   // ST r4,[r0-5]
    tb_mem[8]  = enc(6, 5, 0, 4'hC);   // ST r5,[r0-4]
    tb_mem[9]  = enc(5, 1, 0, 4'h3);   // LD r1,[r0+3]
    tb_mem[10] = enc(6, 1, 0, 4'hD);   // ST r1,[r0-3]
    tb_mem[11] = enc(0, 0, 1, 4'h4);   // ADD r0,r1,r2
    tb_mem[12] = enc(6, 0, 0, 4'hE);   // ST r0,[r0-2]
    tb_mem[13] = enc(1, 6, 2, 4'h2);   // SUB r6,r2,r1
    tb_mem[14] = enc(6, 6, 0, 4'hF);   // ST r6,[r0-1]
    tb_mem[15] = enc(7, 1, 2, 4'h5);   // BEQ r1,r2 (not taken)
    tb_mem[16] = enc(7, 3, 3, 4'hF);   // BEQ r3,r3,-1 (taken loop)
    tb_mem[13'h1FF8] = 13'd5;
    tb_mem[13'h1FF9] = 13'd3;
    sync_ref_mem();
    start_run(20, 2);
    chk("busy_running", busy, 1);
    wait_done(20);
    chk("st_add", tb_mem[13'h1FFA], 13'd8);
    chk("st_addi_neg", tb_mem[13'h1FFB], 13'h1FFE);
    chk("st_addi_wrap", tb_mem[13'h1FFC], 13'h1FFF);
    chk("st_ld_slow", tb_mem[13'h1FFD], 13'h0ABC);
    chk("st_r0_zero", tb_mem[13'h1FFE], 13'h0000);
    chk("st_sub_wrap", tb_mem[13'h1FFF], 13'h1547);

    // random programs, zero-wait then random-wait memory
    for (int i = 0; i < 8192; i++) tb_mem[i] = W'($urandom);
    sync_ref_mem();
    start_run(300, 0);
    wait_done(300);
    for (int i = 0; i < 8192; i++) tb_mem[i] = W'($urandom);
    sync_ref_mem();
    start_run(300, 1);
    wait_done(300);

    // reset while a data access is outstanding
    for (int i = 0; i < 8192; i++) tb_mem[i] = '0;
    tb_mem[0] = enc(5, 1, 0, 4'h3);
    reset = 1'b1; wait_mode = 3; mon_en = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
    c = 0;
    while (!(mem_req && mem_addr == 13'd3) && c < 60) begin
      @(negedge clk);
      c++;
    end
    chk("mem_phase_reached", c < 60, 1);
    chk("mem_phase_we", mem_we, 0);
    reset = 1'b1;
    #1;
    chk("abort_mem_req", mem_req, 0);
    chk("abort_pc", pc, 0);
    chk("abort_busy", busy, 0);
    chk("abort_retired", retired, 0);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
